// File: rtl/rv_pkg.sv
// Shared types and constants for the RV32 pipeline.
// Register address/data types used by ID, WB and the register file.
package rv_pkg;

   localparam int XLEN       = 32;
   localparam int NUM_REGS   = 32;
   localparam int REG_ADDR_W = $clog2(NUM_REGS);
   localparam int SB_CNT_W   = 2;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [XLEN-1:0]       word_t;

   localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: per-register in-flight counters,
// busy lookups for the two ID sources and a sticky overflow flag.
module wb_scoreboard
   import rv_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int SB_CNT_W = 2
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      set_en,
   input  reg_addr_t set_addr,
   input  logic      dec_en,
   input  reg_addr_t dec_addr,
   input  logic      flush,
   input  reg_addr_t rs1_addr,
   input  reg_addr_t rs2_addr,
   output logic      rs1_busy,
   output logic      rs2_busy,
   output logic      overflow
);

   localparam logic [SB_CNT_W-1:0] CNT_ONE = SB_CNT_W'(1);
   localparam logic [SB_CNT_W-1:0] CNT_MAX = '1;

   logic [SB_CNT_W-1:0] cnt [NUM_REGS];
   logic [NUM_REGS-1:0] inc_vec;
   logic [NUM_REGS-1:0] dec_vec;
   logic [NUM_REGS-1:0] sat_vec;
   logic                ovf_hit;

   // A source is busy unless its last outstanding write retires now.
   function automatic logic busy_of(input reg_addr_t a,
                                    input logic [SB_CNT_W-1:0] c);
      return (c != '0) &&
             !((c == CNT_ONE) && dec_en && (dec_addr == a));
   endfunction

   // Decode per-register increment/decrement and saturation.
   always_comb begin
      inc_vec = '0;
      dec_vec = '0;
      sat_vec = '0;
      for (int r = 1; r < NUM_REGS; r++) begin
         inc_vec[r] = set_en && (set_addr == reg_addr_t'(r));
         dec_vec[r] = dec_en && (dec_addr == reg_addr_t'(r));
         sat_vec[r] = (cnt[r] == CNT_MAX);
      end
      ovf_hit = !flush && |(inc_vec & ~dec_vec & sat_vec);
   end

   // Counter update: flush wins, simultaneous inc/dec cancel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      end else begin
         cnt[0] <= '0;
         for (int r = 1; r < NUM_REGS; r++) begin
            if (flush) begin
               cnt[r] <= '0;
            end else if (inc_vec[r] && !dec_vec[r]) begin
               if (cnt[r] != CNT_MAX) cnt[r] <= cnt[r] + CNT_ONE;
            end else if (dec_vec[r] && !inc_vec[r]) begin
               if (cnt[r] != '0) cnt[r] <= cnt[r] - CNT_ONE;
            end
         end
      end
   end

   // Sticky overflow: issue to a saturated register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) overflow <= 1'b0;
      else if (ovf_hit) overflow <= 1'b1;
   end

   assign rs1_busy = busy_of(rs1_addr, cnt[rs1_addr]);
   assign rs2_busy = busy_of(rs2_addr, cnt[rs2_addr]);

endmodule

// File: rtl/gpr_file_scoreboard.sv
// Architectural register file with WB write-through bypass
// and scoreboard-driven ID hazard stall.
module gpr_file_scoreboard
   import rv_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int NUM_REGS = 32,
   parameter int SB_CNT_W = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wb_write_en_in,
   input  reg_addr_t       wb_write_addr_in,
   input  logic [XLEN-1:0] wb_write_data_in,
   input  reg_addr_t       rs1_addr_in,
   input  reg_addr_t       rs2_addr_in,
   input  logic            rs1_used_in,
   input  logic            rs2_used_in,
   output logic [XLEN-1:0] rs1_data_out,
   output logic [XLEN-1:0] rs2_data_out,
   input  logic            sb_set_en_in,
   input  reg_addr_t       sb_set_addr_in,
   input  logic            flush_in,
   output logic            hazard_stall_out,
   output logic            sb_overflow_out
);

   logic [XLEN-1:0] regs [NUM_REGS];
   logic            rs1_busy;
   logic            rs2_busy;

   // x0 is hardwired; WB data is forwarded on an address match.
   function automatic logic [XLEN-1:0] read_port(input reg_addr_t a,
                                                 input logic [XLEN-1:0] q);
      if (a == REG_ZERO) return '0;
      if (wb_write_en_in && (wb_write_addr_in == a)) return wb_write_data_in;
      return q;
   endfunction

   // Register storage; writes to x0 are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      end else if (wb_write_en_in && (wb_write_addr_in != REG_ZERO)) begin
         regs[wb_write_addr_in] <= wb_write_data_in;
      end
   end

   assign rs1_data_out = read_port(rs1_addr_in, regs[rs1_addr_in]);
   assign rs2_data_out = read_port(rs2_addr_in, regs[rs2_addr_in]);

   wb_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .SB_CNT_W (SB_CNT_W)
   ) u_sb (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_en   (sb_set_en_in),
      .set_addr (sb_set_addr_in),
      .dec_en   (wb_write_en_in),
      .dec_addr (wb_write_addr_in),
      .flush    (flush_in),
      .rs1_addr (rs1_addr_in),
      .rs2_addr (rs2_addr_in),
      .rs1_busy (rs1_busy),
      .rs2_busy (rs2_busy),
      .overflow (sb_overflow_out)
   );

   assign hazard_stall_out = (rs1_used_in & rs1_busy) |
                             (rs2_used_in & rs2_busy);

endmodule

// File: tb/tb_gpr_file_scoreboard.sv
// Directed bench for gpr_file_scoreboard: one vector per cycle,
// plus a hand-written asynchronous-reset sequence.
module tb_gpr_file_scoreboard;
   import rv_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        we = 1'b0;
   reg_addr_t   wa = '0;
   logic [31:0] wd = '0;
   reg_addr_t   r1 = '0;
   reg_addr_t   r2 = '0;
   logic        u1 = 1'b0;
   logic        u2 = 1'b0;
   logic        se = 1'b0;
   reg_addr_t   sa = '0;
   logic        fl = 1'b0;
   logic [31:0] d1;
   logic [31:0] d2;
   logic        stall;
   logic        ovf;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   gpr_file_scoreboard dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .wb_write_en_in   (we),
      .wb_write_addr_in (wa),
      .wb_write_data_in (wd),
      .rs1_addr_in      (r1),
      .rs2_addr_in      (r2),
      .rs1_used_in      (u1),
      .rs2_used_in      (u2),
      .rs1_data_out     (d1),
      .rs2_data_out     (d2),
      .sb_set_en_in     (se),
      .sb_set_addr_in   (sa),
      .flush_in         (fl),
      .hazard_stall_out (stall),
      .sb_overflow_out  (ovf)
   );

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic        u1;
      logic        u2;
      logic        se;
      logic [4:0]  sa;
      logic        fl;
      logic [31:0] e1;
      logic [31:0] e2;
      logic        es;
      logic        eo;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(
      input logic we_, input logic [4:0] wa_, input logic [31:0] wd_,
      input logic [4:0] r1_, input logic [4:0] r2_,
      input logic u1_, input logic u2_,
      input logic se_, input logic [4:0] sa_, input logic fl_,
      input logic [31:0] e1_, input logic [31:0] e2_,
      input logic es_, input logic eo_);
      vec_t v;
      v.we = we_; v.wa = wa_; v.wd = wd_;
      v.r1 = r1_; v.r2 = r2_; v.u1 = u1_; v.u2 = u2_;
      v.se = se_; v.sa = sa_; v.fl = fl_;
      v.e1 = e1_; v.e2 = e2_; v.es = es_; v.eo = eo_;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
      end
   endtask

   task automatic idle();
      we = 0; wa = '0; wd = '0; r1 = '0; r2 = '0;
      u1 = 0; u2 = 0; se = 0; sa = '0; fl = 0;
   endtask

   task automatic drive(input vec_t v);
      we = v.we; wa = v.wa; wd = v.wd;
      r1 = v.r1; r2 = v.r2; u1 = v.u1; u2 = v.u2;
      se = v.se; sa = v.sa; fl = v.fl;
   endtask

   initial begin
      // we  wa  wd            r1  r2  u1 u2 se sa  fl  e1            e2            es eo
      tbl.push_back(mk(0, 0,  0,            5, 31, 0, 0, 0, 0,  0, 0,            0,            0, 0));
      tbl.push_back(mk(1, 5,  32'hDEADBEEF, 5, 31, 0, 0, 0, 0,  0, 32'hDEADBEEF, 0,            0, 0));
      tbl.push_back(mk(0, 0,  0,            5, 0,  0, 0, 0, 0,  0, 32'hDEADBEEF, 0,            0, 0));
      tbl.push_back(mk(1, 0,  32'h12345678, 0, 0,  1, 0, 1, 0,  0, 0,            0,            0, 0));
      tbl.push_back(mk(0, 0,  0,            0, 0,  1, 1, 0, 0,  0, 0,            0,            0, 0));
      tbl.push_back(mk(0, 0,  0,            7, 0,  1, 0, 1, 7,  0, 0,            0,            0, 0));
      tbl.push_back(mk(0, 0,  0,            7, 0,  1, 0, 0, 0,  0, 0,            0,            1, 0));
      tbl.push_back(mk(0, 0,  0,            7, 0,  1, 0, 0, 0,  0, 0,            0,            1, 0));
      tbl.push_back(mk(1, 7,  32'hA5,       7, 0,  1, 0, 0, 0,  0, 32'hA5,       0,            0, 0));
      tbl.push_back(mk(0, 0,  0,            7, 0,  1, 0, 0, 0,  0, 32'hA5,       0,            0, 0));
      tbl.push_back(mk(0, 0,  0,            0, 0,  0, 0, 1, 9,  0, 0,            0,            0, 0));
      tbl.push_back(mk(0, 0,  0,            9, 0,  1, 0, 1, 9,  0, 0,            0,            1, 0));
      tbl.push_back(mk(1, 9,  32'h11,       9, 0,  1, 0, 0, 0,  0, 32'h11,       0,            1, 0));
      tbl.push_back(mk(0, 0,  0,            0, 9,  0, 1, 0, 0,  0, 0,            32'h11,       1, 0));
      tbl.push_back(mk(1, 9,  32'h22,       0, 9,  0, 1, 0, 0,  0, 0,            32'h22,       0, 0));
      tbl.push_back(mk(0, 0,  0,            0, 9,  0, 1, 1, 9,  0, 0,            32'h22,       0, 0));
      tbl.push_back(mk(1, 9,  32'h33,       0, 9,  0, 1, 1, 9,  0, 0,            32'h33,       0, 0));
      tbl.push_back(mk(0, 0,  0,            0, 9,  0, 1, 0, 0,  0, 0,            32'h33,       1, 0));
      tbl.push_back(mk(1, 9,  32'h44,       0, 9,  0, 1, 0, 0,  0, 0,            32'h44,       0, 0));
      tbl.push_back(mk(0, 0,  0,            0, 0,  0, 0, 1, 3,  0, 0,            0,            0, 0));
      tbl.push_back(mk(0, 0,  0,            0, 0,  0, 0, 1, 3,  0, 0,            0,            0, 0));
      tbl.push_back(mk(0, 0,  0,            0, 0,  0, 0, 1, 3,  0, 0,            0,            0, 0));
      tbl.push_back(mk(0, 0,  0,            3, 0,  0, 0, 1, 3,  0, 0,            0,            0, 0));
      tbl.push_back(mk(0, 0,  0,            3, 0,  1, 0, 1, 12, 0, 0,            0,            1, 1));
      tbl.push_back(mk(1, 31, 32'hCAFE0001, 3, 12, 1, 1, 0, 0,  1, 0,            0,            1, 1));
      tbl.push_back(mk(0, 0,  0,            3, 12, 1, 1, 0, 0,  0, 0,            0,            0, 1));
      tbl.push_back(mk(1, 3,  32'h77,       3, 0,  1, 0, 0, 0,  0, 32'h77,       0,            0, 1));
      tbl.push_back(mk(0, 0,  0,            3, 31, 1, 0, 0, 0,  0, 32'h77,       32'hCAFE0001, 0, 1));
      tbl.push_back(mk(0, 0,  0,            0, 0,  0, 0, 1, 3,  0, 0,            0,            0, 1));
      tbl.push_back(mk(0, 0,  0,            3, 0,  1, 0, 0, 0,  0, 32'h77,       0,            1, 1));
      tbl.push_back(mk(1, 3,  32'h78,       3, 0,  1, 0, 0, 0,  0, 32'h78,       0,            0, 1));

      idle();
      r1 = 5'd5;
      r2 = 5'd31;
      u1 = 1;
      #2;
      chk("reset_rs1", d1, 32'h0);
      chk("reset_rs2", d2, 32'h0);
      chk("reset_stall", {31'b0, stall}, 32'h0);
      chk("reset_ovf", {31'b0, ovf}, 32'h0);
      @(negedge clk);
      rst_n = 1;

      foreach (tbl[i]) begin
         @(posedge clk);
         #1;
         drive(tbl[i]);
         #3;
         chk($sformatf("v%0d_rs1", i), d1, tbl[i].e1);
         chk($sformatf("v%0d_rs2", i), d2, tbl[i].e2);
         chk($sformatf("v%0d_stall", i), {31'b0, stall}, {31'b0, tbl[i].es});
         chk($sformatf("v%0d_ovf", i), {31'b0, ovf}, {31'b0, tbl[i].eo});
      end

      // x4 = 0x55 with two issues pending, then reset mid-cycle
      @(posedge clk); #1;
      idle(); we = 1; wa = 5'd4; wd = 32'h55;
      @(posedge clk); #1;
      idle(); se = 1; sa = 5'd4;
      @(posedge clk); #1;
      idle(); se = 1; sa = 5'd4;
      @(posedge clk); #1;
      idle(); r1 = 5'd4; u1 = 1;
      #2;
      chk("pre_rst_rs1", d1, 32'h55);
      chk("pre_rst_stall", {31'b0, stall}, 32'h1);
      chk("pre_rst_ovf", {31'b0, ovf}, 32'h1);
      rst_n = 0;
      #1;
      chk("async_rst_rs1", d1, 32'h0);
      chk("async_rst_stall", {31'b0, stall}, 32'h0);
      chk("async_rst_ovf", {31'b0, ovf}, 32'h0);
      @(negedge clk);
      rst_n = 1;
      @(posedge clk); #1;
      r1 = 5'd4; u1 = 1; r2 = 5'd5; u2 = 1;
      #3;
      chk("post_rst_rs1", d1, 32'h0);
      chk("post_rst_rs2", d2, 32'h0);
      chk("post_rst_stall", {31'b0, stall}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/gpr_file_scoreboard.md
# gpr_file_scoreboard

Architectural register file for the 32-bit RISC-V pipeline: the receiving end of the write-back interface (`wb_write_*`). It also supplies the two ID-stage read ports, with same-cycle write-through bypass. A per-register pending-write scoreboard is set by ID at issue and cleared by WB at retire. From it the block drives the ID hazard stall, so a read never returns stale data.

## Interface
Parameters:
- `XLEN`, 32, data width
- `NUM_REGS`, 32, architectural registers (address width = clog2, 5)
- `SB_CNT_W`, 2, scoreboard counter width per register (max 3 in flight)

Ports:
- `clk`  in  1  clock, all state updates on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `wb_write_en_in`  in  1  write enable from WB stage
- `wb_write_addr_in`  in  5  destination register
- `wb_write_data_in`  in  XLEN  write data
- `rs1_addr_in`, `rs2_addr_in`  in  5 each  ID read addresses
- `rs1_used_in`, `rs2_used_in`  in  1 each  instruction in ID actually reads rs1/rs2
- `rs1_data_out`, `rs2_data_out`  out  XLEN each  read data (combinational)
- `sb_set_en_in`  in  1  ID issues an instruction that writes rd (asserted only when not stalled)
- `sb_set_addr_in`  in  5  rd of issuing instruction
- `flush_in`  in  1  pipeline flush; clears all pending counts
- `hazard_stall_out`  out  1  ID must hold; a used source has a pending write not retiring this cycle
- `sb_overflow_out`  out  1  sticky error: issue attempted on a register whose counter is saturated

## Operation
- Storage: `NUM_REGS` x `XLEN` flops; x0 is not stored, reads as 0, writes to x0 are dropped.
- Write: on a rising edge with `wb_write_en_in`=1 and addr≠0, `regs[addr] <= wb_write_data_in`.
- Read: `rsN_data_out` = 0 if addr=0; else `wb_write_data_in` if `wb_write_en_in` and `wb_write_addr_in`==addr (bypass); else `regs[addr]`.
- Scoreboard: `cnt[r]`, SB_CNT_W bits, r=1..31; `cnt[0]` is constant 0.
  - inc = `sb_set_en_in` and addr=r, r≠0.
  - dec = `wb_write_en_in` and addr=r.
  - inc and dec same register, same cycle: count unchanged.
  - inc only: +1 if cnt<max. If cnt=max, count holds and `sb_overflow_out` is set to 1; it stays set until reset.
  - dec only: −1 if cnt>0, else holds 0 (no underflow).
  - `flush_in`=1 zeroes all counters and has priority over inc/dec that cycle. Register writes still occur.
- Busy: `rsN_busy` = cnt[addr]≠0 and not (cnt[addr]==1 and the same-cycle WB write targets addr). A retiring final write is covered by the bypass.
- `hazard_stall_out` = (rs1_used_in & rs1_busy) | (rs2_used_in & rs2_busy). Combinational, not gated by `flush_in`.
- A register with two issues in flight stays busy until the second WB write is decremented.

## Timing
- Reset (async assert, sync-released by the system): all regs=0, all cnt=0, `sb_overflow_out`=0. Consequently all read data=0 and `hazard_stall_out`=0.
- Reset mid-operation: all state is cleared immediately, regardless of clock.
- Write latency: data is visible on read ports in the same cycle (bypass) and from storage on every later cycle.
- Scoreboard update: a set in cycle N makes busy visible in cycle N+1; a clear in cycle N releases busy in cycle N (final count only).
- All outputs except `sb_overflow_out` are combinational from inputs and state. `sb_overflow_out` is registered.

## Structure
- Shared package `rv_pkg`: `XLEN`, `REG_ADDR_W`, `reg_addr_t`, `word_t`, and the constant `REG_ZERO` = 5'd0.
- One sub-module, `wb_scoreboard`: counter array, inc/dec/flush logic, busy lookups, overflow flag.
- The top level holds the storage array, the bypass muxes, and the stall OR.

## Test plan
- Reset, then read x5/x31 -> 0. Write x5=0xDEADBEEF in cycle N with rs1=x5 in N -> rs1_data=0xDEADBEEF in N (bypass) and in N+1 (storage).
- Write x0=0x12345678 -> subsequent read of x0=0; no stall on x0 even after sb_set to x0.
- sb_set x7 in N, rs1=x7 with rs1_used=1 in N+1 -> stall=1. WB write x7=0xA5 in N+3 -> stall=0 and rs1_data=0xA5 in N+3.
- Two sb_sets to x9 (cnt=2), one WB write -> stall stays 1. Second WB write -> stall 0. Set and WB to x9 in the same cycle with cnt=1 -> cnt stays 1, stall 1.
- Four sb_sets to x3 without retire -> cnt=3, sb_overflow_out=1 from the next cycle. flush_in -> all stalls 0; a following WB to x3 leaves cnt=0. Overflow stays 1 until rst_n.
- Assert rst_n=0 asynchronously mid-stream with cnt[4]=2 and x4=0x55 -> immediate x4 read 0, stall 0, overflow 0.
